// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared types and constants for the DDS DAC output path.
//                Defines the serial frame layout, the DAC power-down
//                encodings and the transmitter state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  // Frame layout: 6 pad bits, 2 power-down bits, 16 sample bits, MSB first
  localparam int FRAME_BITS    = 24;
  localparam int CTRL_PAD_BITS = 6;
  localparam int SAMPLE_BITS   = 16;
  localparam int BIT_CNT_W     = 5;

  // DAC power-down control encodings
  localparam logic [1:0] PWR_NORMAL   = 2'b00;
  localparam logic [1:0] PWR_1K_GND   = 2'b01;
  localparam logic [1:0] PWR_100K_GND = 2'b10;
  localparam logic [1:0] PWR_HIZ      = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } dac_state_e;

  // Assemble the on-wire frame from the latched control bits and sample
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [1:0]             pm,
    input logic [SAMPLE_BITS-1:0] smp
  );
    return {{CTRL_PAD_BITS{1'b0}}, pm, smp};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx_if
//  Description : Sample handshake between the waveform selector (master)
//                and the serial DAC transmitter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_spi_tx_if;
  import dds_pkg::*;

  logic [SAMPLE_BITS-1:0] SampleIn;
  logic [1:0]             PowerMode;
  logic                   SampleValid;
  logic                   SampleReady;

  modport master (
    output SampleIn,
    output PowerMode,
    output SampleValid,
    input  SampleReady
  );

  modport slave (
    input  SampleIn,
    input  PowerMode,
    input  SampleValid,
    output SampleReady
  );

endinterface
`default_nettype wire

// File: rtl/dac_spi_tx_sclk_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sclk_tick_gen
//  Description : Divider for the serial clock. Counts 0..CLK_DIV-1 while
//                enabled and flags the last count as a one-cycle phase tick
//                marking the end of an SCLK half-period.
//  Revision    : 1.0 - initial release
// ============================================================================
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_en,
  input  wire logic i_clr,
  output logic      o_tick
);

  localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Free-running half-period counter, restarted at the start of each frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Serial DAC transmitter. Accepts a 16-bit sample plus power
//                mode, frames it as {6'b0, PowerMode, sample} and shifts it
//                MSB first on SYNC/SCLK/DIN. DIN changes on SCLK rising
//                edges so it is stable around every falling edge.
//                Optional macro DAC_OFFSET_BIN_EN inverts the sample MSB
//                (two's complement to offset binary) before latching.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dac_spi_tx_if.slave   sample_bus,
  output logic          DacSyncN,
  output logic          DacSclk,
  output logic          DacDin,
  output logic          Busy
);

  localparam logic [BIT_CNT_W-1:0] c_TOP_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  dac_state_e              r_state;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic                    r_phase_hi;
  logic                    r_last;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_sync_n;
  logic                    r_sclk;
  logic                    r_din;

  logic                    w_accept;
  logic                    w_tick;
  logic [SAMPLE_BITS-1:0]  w_sample;

`ifdef DAC_OFFSET_BIN_EN
  assign w_sample = {~sample_bus.SampleIn[SAMPLE_BITS-1], sample_bus.SampleIn[SAMPLE_BITS-2:0]};
`else
  assign w_sample = sample_bus.SampleIn;
`endif

  // Ready mirrors IDLE exactly, so the handshake is evaluated on the flop
  assign w_accept = r_ready && sample_bus.SampleValid;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state != IDLE),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  // Frame sequencer; pin outputs are registered one cycle behind the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_bit_cnt  <= '0;
      r_phase_hi <= 1'b0;
      r_last     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_sync_n   <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_frame    <= build_frame(sample_bus.PowerMode, w_sample);
            r_bit_cnt  <= c_TOP_BIT;
            r_phase_hi <= 1'b0;
            r_last     <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            if (!r_phase_hi) begin
              // SCLK rising edge: move DIN to the next bit unless on the last
              r_phase_hi <= 1'b1;
              if (r_bit_cnt == '0) begin
                r_last <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
              end
            end else if (r_last) begin
              r_state <= HOLD;
            end else begin
              r_phase_hi <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      r_sync_n <= !((r_state == SETUP) || (r_state == SHIFT));
      r_sclk   <= !((r_state == SHIFT) && !r_phase_hi);
      r_din    <= ((r_state == SETUP) || (r_state == SHIFT)) ? r_frame[r_bit_cnt] : 1'b0;
    end
  end

  assign sample_bus.SampleReady = r_ready;
  assign Busy                   = r_busy;
  assign DacSyncN               = r_sync_n;
  assign DacSclk                = r_sclk;
  assign DacDin                 = r_din;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_tx
//  Description : Self-checking bench for dac_spi_tx. Two instances run side
//                by side (CLK_DIV=2 and CLK_DIV=4). A timing model derived
//                from the frame rules predicts every pin on every cycle;
//                captured frames are also checked against literal words.
//                Honours DAC_OFFSET_BIN_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;
  import dds_pkg::*;

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [23:0] c_OFS = 24'h008000;
`else
  localparam logic [23:0] c_OFS = 24'h000000;
`endif

  typedef struct {
    int          dut;
    logic [23:0] w;
    int          n;
    longint      len;
    longint      gap;
  } frame_t;

  typedef struct {
    int     dut;
    longint c;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dac_spi_tx_if bus0();
  dac_spi_tx_if bus1();
  logic sync0, sclk0, din0, busy0;
  logic sync1, sclk1, din1, busy1;

  dac_spi_tx #(.CLK_DIV(2)) u_dut0 (
    .clk (clk), .reset (reset), .sample_bus (bus0.slave),
    .DacSyncN (sync0), .DacSclk (sclk0), .DacDin (din0), .Busy (busy0)
  );

  dac_spi_tx #(.CLK_DIV(4)) u_dut1 (
    .clk (clk), .reset (reset), .sample_bus (bus1.slave),
    .DacSyncN (sync1), .DacSclk (sclk1), .DacDin (din1), .Busy (busy1)
  );

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  int          hdiv [2] = '{2, 4};
  bit          active [2];
  bit          exp_ready [2];
  bit          acc_now [2];
  longint      kacc [2];
  logic [23:0] mword [2];
  logic [23:0] cap [2];
  int          capn [2];
  int          sclk_falls [2];
  bit          prev_sclk [2];
  bit          prev_sync [2];
  longint      fall_c [2];
  longint      rise_c [2];
  longint      gap_c [2];
  frame_t      frames [$];
  acc_t        accs [$];
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_word(input logic [1:0] pm, input logic [15:0] s);
    logic [15:0] t;
    t = s;
`ifdef DAC_OFFSET_BIN_EN
    t[15] = ~t[15];
`endif
    return {6'b0, pm, t};
  endfunction

  // Expected {ready, sync_n, sclk, din} d cycles after an accept edge
  function automatic logic [3:0] model_out(input int h, input longint d, input logic [23:0] w);
    logic   r, sy, sc, dn;
    longint m;
    int     p;
    bit     hi;
    r  = (d >= 50 * h);
    sy = !(d >= 1 && d < 1 + 49 * h);
    sc = 1'b1;
    dn = 1'b0;
    if (d >= 1 && d < 1 + h) begin
      dn = w[23];
    end else if (d >= 1 + h && d < 1 + 49 * h) begin
      m  = d - 1 - h;
      p  = int'(m / (2 * h));
      hi = (m % (2 * h)) >= h;
      sc = hi;
      dn = hi ? w[(p < 23) ? 22 - p : 0] : w[23 - p];
    end
    return {r, sy, sc, dn};
  endfunction

  task automatic set_in(input int i, input logic v, input logic [17:0] e);
    if (i == 0) begin
      bus0.SampleValid = v; bus0.PowerMode = e[17:16]; bus0.SampleIn = e[15:0];
    end else begin
      bus1.SampleValid = v; bus1.PowerMode = e[17:16]; bus1.SampleIn = e[15:0];
    end
  endtask

  // Advance one clock, update the model and compare every pin of both DUTs
  task automatic tick();
    logic [3:0]  got, e;
    logic        v, bsy;
    logic [15:0] s;
    logic [1:0]  pm;
    for (int i = 0; i < 2; i++) begin
      acc_now[i] = 1'b0;
      v  = (i == 0) ? bus0.SampleValid : bus1.SampleValid;
      s  = (i == 0) ? bus0.SampleIn    : bus1.SampleIn;
      pm = (i == 0) ? bus0.PowerMode   : bus1.PowerMode;
      if (reset && v && exp_ready[i]) begin
        active[i]  = 1'b1;
        kacc[i]    = cyc + 1;
        mword[i]   = model_word(pm, s);
        acc_now[i] = 1'b1;
        accs.push_back('{i, cyc + 1});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? {bus0.SampleReady, sync0, sclk0, din0} : {bus1.SampleReady, sync1, sclk1, din1};
      bsy = (i == 0) ? busy0 : busy1;
      if (!reset) active[i] = 1'b0;
      e = active[i] ? model_out(hdiv[i], cyc - kacc[i], mword[i]) : 4'b1110;
      chk($sformatf("dut%0d ready", i),  got[3], e[3]);
      chk($sformatf("dut%0d busy", i),   bsy,    !e[3]);
      chk($sformatf("dut%0d sync_n", i), got[2], e[2]);
      chk($sformatf("dut%0d sclk", i),   got[1], e[1]);
      chk($sformatf("dut%0d din", i),    got[0], e[0]);
      exp_ready[i] = e[3];
      if (prev_sclk[i] && !got[1]) sclk_falls[i]++;
      if (!reset) begin
        cap[i]  = '0;
        capn[i] = 0;
      end else if (prev_sclk[i] && !got[1] && !got[2]) begin
        cap[i] = {cap[i][22:0], got[0]};
        capn[i]++;
      end
      if (prev_sync[i] && !got[2]) begin
        fall_c[i] = cyc;
        gap_c[i]  = cyc - rise_c[i];
      end
      if (!prev_sync[i] && got[2]) begin
        if (reset) frames.push_back('{i, cap[i], capn[i], cyc - fall_c[i], gap_c[i]});
        rise_c[i] = cyc;
        cap[i]    = '0;
        capn[i]   = 0;
      end
      prev_sclk[i] = got[1];
      prev_sync[i] = got[2];
    end
  endtask

  // Source side: present the next queued sample once the current one is taken
  task automatic service();
    if (acc_now[0]) begin
      if (q0.size() > 0) set_in(0, 1'b1, q0.pop_front());
      else               set_in(0, 1'b0, '0);
    end
    if (acc_now[1]) begin
      if (q1.size() > 0) set_in(1, 1'b1, q1.pop_front());
      else               set_in(1, 1'b0, '0);
    end
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = !bus0.SampleValid && !bus1.SampleValid && (q0.size() == 0) && (q1.size() == 0);
    for (int i = 0; i < 2; i++)
      if (active[i] && (cyc - kacc[i] < 50 * hdiv[i])) ok = 1'b0;
    return ok;
  endfunction

  task automatic run_phase(input int bound);
    int n;
    n = 0;
    while (n < bound && !all_idle()) begin
      tick();
      service();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL timeout: traffic not drained within %0d cycles", bound);
    end
    repeat (3) tick();
  endtask

  task automatic pin_check(input string tag);
    chk({tag, " ready0"}, bus0.SampleReady, 1'b1);
    chk({tag, " busy0"},  busy0, 1'b0);
    chk({tag, " sync0"},  sync0, 1'b1);
    chk({tag, " sclk0"},  sclk0, 1'b1);
    chk({tag, " din0"},   din0,  1'b0);
    chk({tag, " ready1"}, bus1.SampleReady, 1'b1);
    chk({tag, " sync1"},  sync1, 1'b1);
    chk({tag, " sclk1"},  sclk1, 1'b1);
    chk({tag, " din1"},   din1,  1'b0);
  endtask

  initial begin
    frame_t      f0 [$];
    frame_t      f1 [$];
    longint      a0 [$];
    longint      a1 [$];
    int          falls_before [2];
    int          n;

    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = 1'b1; prev_sclk[i] = 1'b1; prev_sync[i] = 1'b1;
      active[i] = 1'b0; cap[i] = '0; capn[i] = 0; sclk_falls[i] = 0;
      fall_c[i] = 0; rise_c[i] = 0; gap_c[i] = 0;
    end

    // Reset held with valid asserted: nothing may be accepted or toggled
    reset = 1'b1;
    set_in(0, 1'b1, {PWR_NORMAL, 16'h1234});
    set_in(1, 1'b1, {PWR_1K_GND, 16'hA5C3});
    #1 reset = 1'b0;
    #1 pin_check("reset");
    repeat (4) tick();
    chk("reset sclk edges dut0", sclk_falls[0], 0);
    chk("reset sclk edges dut1", sclk_falls[1], 0);
    pin_check("reset held");

    // Single frame, power mode and offset-binary words on dut0 back to back;
    // two queued samples on dut1
    q0.push_back({PWR_HIZ, 16'hFFFF});
    q0.push_back({PWR_NORMAL, 16'h0000});
    q1.push_back({PWR_100K_GND, 16'h0F0F});
    reset = 1'b1;
    run_phase(3000);

    foreach (frames[j]) if (frames[j].dut == 0) f0.push_back(frames[j]); else f1.push_back(frames[j]);
    foreach (accs[j])   if (accs[j].dut == 0)   a0.push_back(accs[j].c);  else a1.push_back(accs[j].c);

    chk("dut0 frame count", f0.size(), 3);
    chk("dut0 accept count", a0.size(), 3);
    if (f0.size() == 3) begin
      chk("dut0 word 1234",   f0[0].w, 24'h001234 ^ c_OFS);
      chk("dut0 word pm11",   f0[1].w, 24'h03FFFF ^ c_OFS);
      chk("dut0 word zero",   f0[2].w, 24'h000000 ^ c_OFS);
      chk("dut0 bits",        f0[0].n, 24);
      chk("dut0 sync low",    f0[0].len, 98);
    end
    if (a0.size() == 3) begin
      chk("dut0 accept spacing a", a0[1] - a0[0], 101);
      chk("dut0 accept spacing b", a0[2] - a0[1], 101);
    end
    chk("dut1 frame count", f1.size(), 2);
    chk("dut1 accept count", a1.size(), 2);
    if (f1.size() == 2) begin
      chk("dut1 word first",  f1[0].w, 24'h01A5C3 ^ c_OFS);
      chk("dut1 word second", f1[1].w, 24'h020F0F ^ c_OFS);
      chk("dut1 bits",        f1[1].n, 24);
      chk("dut1 sync low",    f1[0].len, 196);
      chk("dut1 sync gap ge 4", (f1[1].gap >= 4), 1'b1);
    end
    if (a1.size() == 2) chk("dut1 accept spacing", a1[1] - a1[0], 201);

    // Mid-frame reset after the 10th falling edge of dut0
    frames.delete();
    accs.delete();
    set_in(0, 1'b1, {PWR_NORMAL, 16'hBEEF});
    set_in(1, 1'b1, {PWR_1K_GND, 16'h1357});
    n = 0;
    while (n < 400 && capn[0] < 10) begin
      tick();
      service();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout: 10th falling edge not seen within 400 cycles");
    end
    #2 reset = 1'b0;
    #1 pin_check("async reset");
    falls_before[0] = sclk_falls[0];
    falls_before[1] = sclk_falls[1];
    set_in(0, 1'b1, {PWR_NORMAL, 16'hC0DE});
    set_in(1, 1'b1, {PWR_HIZ, 16'h2468});
    repeat (3) tick();
    chk("midreset sclk edges dut0", sclk_falls[0] - falls_before[0], 0);
    chk("midreset sclk edges dut1", sclk_falls[1] - falls_before[1], 0);
    chk("partial frame dropped", frames.size(), 0);
    reset = 1'b1;
    run_phase(3000);

    f0.delete();
    f1.delete();
    foreach (frames[j]) if (frames[j].dut == 0) f0.push_back(frames[j]); else f1.push_back(frames[j]);
    chk("after reset dut0 frames", f0.size(), 1);
    chk("after reset dut1 frames", f1.size(), 1);
    if (f0.size() == 1) begin
      chk("after reset dut0 word", f0[0].w, 24'h00C0DE ^ c_OFS);
      chk("after reset dut0 bits", f0[0].n, 24);
    end
    if (f1.size() == 1) begin
      chk("after reset dut1 word", f1[0].w, 24'h032468 ^ c_OFS);
      chk("after reset dut1 bits", f1[0].n, 24);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC transmitter at the analog end of the DDS output path. It accepts 16-bit samples from the waveform selector's output with a valid/ready handshake. Each sample is framed as a 24-bit word and shifted MSB-first to an external SPI-style DAC (SYNC/SCLK/DIN, DAC8551-class). It sits between the waveform selector and the board DAC pins and sets the maximum output sample rate.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period (H). Legal range ≥1.
- FRAME_BITS, 24: bits per DAC frame. Fixed at 24: 8 control bits followed by 16 data bits.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- SampleIn  input  16  sample from the waveform selector.
- PowerMode  input  2  DAC power-down bits. Latched together with the sample.
- SampleValid  input  1  SampleIn/PowerMode are valid.
- SampleReady  output  1  the block can accept a sample. High only in IDLE.
- DacSyncN  output  1  frame sync, active-low.
- DacSclk  output  1  serial clock. Idles high.
- DacDin  output  1  serial data. The DAC samples it on the falling edge of DacSclk.
- Busy  output  1  a frame is in progress (the inverse of SampleReady).

## Operation
- States:
  - IDLE: SampleReady=1. On SampleValid&SampleReady, latch frame = {6'b0, PowerMode, SampleIn'} and go to SETUP.
  - SETUP: DacSyncN=0, DacSclk=1, DacDin=frame[23]. Lasts H cycles, then go to SHIFT.
  - SHIFT: 24 bit periods, each 2H cycles. SCLK is low for H cycles, then high for H cycles. DacDin advances to the next bit at each SCLK rising edge, except after the last bit. After the 24th high phase, go to HOLD.
  - HOLD: DacSyncN=1, DacSclk=1, DacDin=0. Lasts H cycles, then go to IDLE.
- SampleIn' is SampleIn, with MSB inversion when the offset-binary feature is compiled in (see Configuration).
- Bit counter: 5 bits, counting 23 down to 0. The divider counter counts 0 to H-1 and produces a phase tick at H-1.
- A sample presented while the block is busy is not consumed. SampleValid may stay high; the handshake completes at the next IDLE cycle.
- SampleIn and PowerMode changing mid-frame have no effect, because the frame register holds the latched values.
- Reset values: SampleReady=1, Busy=0, DacSyncN=1, DacSclk=1, DacDin=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: all outputs return to their reset values immediately and asynchronously. The partial frame is discarded. The DAC ignores it because SYNC rises before the 24th falling edge.

## Timing
- Accept at rising edge k. DacSyncN falls at k+1.
- First SCLK falling edge at k+1+H. The n-th falling edge (n=1..24) is at k+1+H+2H(n-1).
- DacSyncN is low for exactly 49H cycles and rises at k+1+49H.
- SampleReady re-asserts at k+1+50H. The earliest next accept is at that edge, so the sample period is at least 50H+1 cycles.
- DacDin is stable for H cycles on both sides of every SCLK falling edge.
- Output latency from accept to DAC update (24th falling edge) is 1+47H cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- DAC_OFFSET_BIN_EN defined: SampleIn[15] is inverted before latching, converting two's-complement to offset binary.
- DAC_OFFSET_BIN_EN undefined: SampleIn passes unchanged (straight binary). This is the default for the existing unsigned waveform generators.

## Structure
- Shared package dds_pkg contains:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - FRAME_BITS;
  - the control-byte pad width (6);
  - the PowerMode encodings: 00 normal, 01 1k to GND, 10 100k to GND, 11 Hi-Z.
- One sub-module, sclk_tick_gen, contains the CLK_DIV counter and produces a one-cycle phase tick. It is enabled only outside IDLE and cleared on entry to SETUP.

## Test plan
- Reset check: hold reset low with SampleValid=1 → SampleReady=1, DacSyncN=1, DacSclk=1, DacDin=0, and no SCLK edges.
- Single frame: CLK_DIV=2, SampleIn=16'h1234, PowerMode=00 → 24 bits captured on SCLK falling edges equal 24'h001234; DacSyncN is low for 98 cycles; SampleReady returns 101 cycles after accept.
- Back-to-back: hold SampleValid high with two samples queued, CLK_DIV=4 → accepts are exactly 201 cycles apart; the second frame carries the second sample; DacSyncN is high for ≥4 cycles between frames.
- Power mode: PowerMode=2'b11, SampleIn=16'hFFFF → captured word 24'h03FFFF.
- Offset binary: with DAC_OFFSET_BIN_EN defined, SampleIn=16'h0000 → 24'h008000. Without it → 24'h000000.
- Mid-frame reset: assert reset after the 10th falling edge → DacSyncN=1 asynchronously, no further SCLK edges; after release the next accepted sample is sent as a complete frame.
